// File: rtl/vending_input_conditioner_pkg.sv
// Shared constants and issue-priority helper for the vending input conditioner.
// Channel indices here match the controller bench's view of the event vector.
package vending_input_conditioner_pkg;

    localparam int CH_COIN = 0;
    localparam int CH_SEL1 = 1;
    localparam int CH_SEL2 = 2;
    localparam int NUM_CH  = 3;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_HOLDOFF         = 2;

    typedef logic [NUM_CH-1:0] ch_mask_t;

    // Coin wins outright; two pending selects go out together so the FSM sees a no-op.
    function automatic ch_mask_t pick_issue(input ch_mask_t pend);
        ch_mask_t sel;
        sel = '0;
        if (pend[CH_COIN]) begin
            sel[CH_COIN] = 1'b1;
        end else if (pend[CH_SEL1] && pend[CH_SEL2]) begin
            sel[CH_SEL1] = 1'b1;
            sel[CH_SEL2] = 1'b1;
        end else if (pend[CH_SEL1]) begin
            sel[CH_SEL1] = 1'b1;
        end else if (pend[CH_SEL2]) begin
            sel[CH_SEL2] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/vending_input_conditioner_if.sv
// Raw sensor lines in, clean event pulses and status out.
// master drives the raw lines (board / bench); slave is the conditioner.
interface vending_input_conditioner_if;
    logic coin_raw;
    logic btn1_raw;
    logic btn2_raw;
    logic quarter_in;
    logic select1;
    logic select2;
    logic event_dropped;
    logic busy;

    modport master (
        output coin_raw, btn1_raw, btn2_raw,
        input  quarter_in, select1, select2, event_dropped, busy
    );

    modport slave (
        input  coin_raw, btn1_raw, btn2_raw,
        output quarter_in, select1, select2, event_dropped, busy
    );
endinterface

// File: rtl/vic_debounce_ch.sv
// One input channel: 2-flop sync, debounce, arming and rising-edge strobe.
// Strobe appears DEBOUNCE_CYCLES+1 edges after raw is first sampled high; no backpressure.
module vic_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync;
    logic [1:0]    fill;
    logic          db;
    logic          db_prev;
    logic          armed;
    logic [CW-1:0] cnt;

    // fill marks when sync holds a real post-reset sample, so a line held high
    // through reset never looks low and never arms the channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1  <= 1'b0;
            sync    <= 1'b0;
            fill    <= 2'b00;
            db      <= 1'b0;
            db_prev <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= raw;
            sync    <= sync_1;
            fill    <= {fill[0], 1'b1};
            db_prev <= db;
            if (sync == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (fill[1] && !sync && !db) begin
                armed <= 1'b1;
            end
        end
    end

    assign rise = db & ~db_prev & armed;

endmodule

// File: rtl/vending_input_conditioner.sv
// Conditions coin/button lines into spaced 1-cycle event pulses, one pending flag per channel.
// Idle latency DEBOUNCE_CYCLES+3 edges; holdoff delays but never drops a pending event.
module vending_input_conditioner
    import vending_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLDOFF         = DEF_HOLDOFF
) (
    input logic clk,
    input logic reset,
    vending_input_conditioner_if.slave io
);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

    ch_mask_t      raw;
    ch_mask_t      rise;
    ch_mask_t      pending;
    ch_mask_t      issue;
    ch_mask_t      dropped;
    logic [HW-1:0] hold;
    logic          quarter_q;
    logic          select1_q;
    logic          select2_q;
    logic          dropped_q;

    assign raw = {io.btn2_raw, io.btn1_raw, io.coin_raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        vic_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .rise  (rise[i])
        );
    end

    always_comb begin
        issue = '0;
        if (hold == '0) begin
            issue = pick_issue(pending);
        end
    end

    // A flag being issued this cycle is free to take the new edge, so only a
    // flag that stays set turns an incoming edge into a drop.
    assign dropped = rise & pending & ~issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            hold      <= '0;
            quarter_q <= 1'b0;
            select1_q <= 1'b0;
            select2_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            pending   <= (pending & ~issue) | rise;
            quarter_q <= issue[CH_COIN];
            select1_q <= issue[CH_SEL1];
            select2_q <= issue[CH_SEL2];
            dropped_q <= |dropped;
            if (|issue) begin
                hold <= HOLD_LOAD;
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end
        end
    end

    assign io.quarter_in    = quarter_q;
    assign io.select1       = select1_q;
    assign io.select2       = select2_q;
    assign io.event_dropped = dropped_q;
    assign io.busy          = (|pending) || (hold != '0);

endmodule

// File: tb/tb_vending_input_conditioner.sv
// Directed bench: cycle-exact vector table for latency/priority/holdoff, plus counted
// sequences for bounce, glitch, reset corners and drop (second instance with long holdoff).
module tb_vending_input_conditioner;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vending_input_conditioner_if vif_a ();
    vending_input_conditioner_if vif_b ();

    vending_input_conditioner dut_a (
        .clk   (clk),
        .reset (reset),
        .io    (vif_a)
    );

    vending_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF        (30)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .io    (vif_b)
    );

    int errors = 0;
    int checks = 0;

    // want = {quarter_in, select1, select2, event_dropped, busy} after the edge
    typedef struct {
        logic       coin;
        logic       btn1;
        logic       btn2;
        logic [4:0] want;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic c, input logic b1, input logic b2,
                       input logic [4:0] w);
        vec_t v;
        v.coin = c;
        v.btn1 = b1;
        v.btn2 = b2;
        v.want = w;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] outs_a();
        return {vif_a.quarter_in, vif_a.select1, vif_a.select2, vif_a.event_dropped, vif_a.busy};
    endfunction

    function automatic logic [4:0] outs_b();
        return {vif_b.quarter_in, vif_b.select1, vif_b.select2, vif_b.event_dropped, vif_b.busy};
    endfunction

    task automatic run_a(input int n, output int nq, output int ns1, output int ns2, output int nd);
        nq = 0; ns1 = 0; ns2 = 0; nd = 0;
        repeat (n) begin
            tick();
            nq  += int'(vif_a.quarter_in);
            ns1 += int'(vif_a.select1);
            ns2 += int'(vif_a.select2);
            nd  += int'(vif_a.event_dropped);
        end
    endtask

    task automatic run_b(input int n, inout int nq, inout int ns1, inout int nd);
        repeat (n) begin
            tick();
            nq  += int'(vif_b.quarter_in);
            ns1 += int'(vif_b.select1);
            nd  += int'(vif_b.event_dropped);
        end
    endtask

    initial begin
        int nq, ns1, ns2, nd;
        int bq, bs1, bd;
        logic [3:0] bounce;

        // coin alone: pulse after edge 7, busy while pending and during holdoff
        add(6, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(1, 1'b1, 1'b0, 1'b0, 5'b00001);
        add(1, 1'b1, 1'b0, 1'b0, 5'b10001);
        add(1, 1'b1, 1'b0, 1'b0, 5'b00001);
        add(3, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(10, 1'b0, 1'b0, 1'b0, 5'b00000);
        // coin + btn2 together: quarter at t, select2 at t+3
        add(6, 1'b1, 1'b0, 1'b1, 5'b00000);
        add(1, 1'b1, 1'b0, 1'b1, 5'b00001);
        add(1, 1'b1, 1'b0, 1'b1, 5'b10001);
        add(2, 1'b1, 1'b0, 1'b1, 5'b00001);
        add(1, 1'b1, 1'b0, 1'b1, 5'b00101);
        add(1, 1'b1, 1'b0, 1'b1, 5'b00001);
        add(3, 1'b1, 1'b0, 1'b1, 5'b00000);
        add(10, 1'b0, 1'b0, 1'b0, 5'b00000);
        // btn1 + btn2 together: both selects in one cycle
        add(6, 1'b0, 1'b1, 1'b1, 5'b00000);
        add(1, 1'b0, 1'b1, 1'b1, 5'b00001);
        add(1, 1'b0, 1'b1, 1'b1, 5'b01101);
        add(1, 1'b0, 1'b1, 1'b1, 5'b00001);
        add(3, 1'b0, 1'b1, 1'b1, 5'b00000);
        add(10, 1'b0, 1'b0, 1'b0, 5'b00000);

        vif_a.coin_raw = 1'b0; vif_a.btn1_raw = 1'b0; vif_a.btn2_raw = 1'b0;
        vif_b.coin_raw = 1'b0; vif_b.btn1_raw = 1'b0; vif_b.btn2_raw = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("reset_outs_a", int'(outs_a()), 0);
        check("reset_outs_b", int'(outs_b()), 0);
        reset = 1'b0;
        repeat (6) tick();
        check("idle_outs_a", int'(outs_a()), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            vif_a.coin_raw = vecs[i].coin;
            vif_a.btn1_raw = vecs[i].btn1;
            vif_a.btn2_raw = vecs[i].btn2;
            tick();
            check($sformatf("vec%0d", i), int'(outs_a()), int'(vecs[i].want));
        end

        // bounce 1,0,1,0 then steady high: exactly one select1
        bounce = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            vif_a.btn1_raw = bounce[i];
            tick();
        end
        vif_a.btn1_raw = 1'b1;
        run_a(25, nq, ns1, ns2, nd);
        check("bounce_select1", ns1, 1);
        check("bounce_others", nq + ns2 + nd, 0);
        vif_a.btn1_raw = 1'b0;
        run_a(12, nq, ns1, ns2, nd);
        check("bounce_release", ns1, 0);

        // 3-cycle glitch is rejected
        vif_a.btn1_raw = 1'b1;
        repeat (3) tick();
        vif_a.btn1_raw = 1'b0;
        run_a(25, nq, ns1, ns2, nd);
        check("glitch_select1", ns1, 0);

        // btn2 held across reset release: nothing until released and pressed again
        vif_a.btn2_raw = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        run_a(30, nq, ns1, ns2, nd);
        check("held_reset_select2", ns2, 0);
        vif_a.btn2_raw = 1'b0;
        run_a(12, nq, ns1, ns2, nd);
        check("held_release_select2", ns2, 0);
        vif_a.btn2_raw = 1'b1;
        run_a(20, nq, ns1, ns2, nd);
        check("held_repress_select2", ns2, 1);
        vif_a.btn2_raw = 1'b0;
        run_a(12, nq, ns1, ns2, nd);

        // reset while coin is pending discards it
        vif_a.coin_raw = 1'b1;
        repeat (7) tick();
        check("pending_busy", int'(vif_a.busy), 1);
        reset = 1'b1;
        vif_a.coin_raw = 1'b0;
        tick();
        check("reset_mid_outs", int'(outs_a()), 0);
        tick();
        reset = 1'b0;
        run_a(25, nq, ns1, ns2, nd);
        check("reset_mid_quarter", nq, 0);
        check("reset_mid_busy", int'(vif_a.busy), 0);

        // second coin edge while coin still pending behind a long holdoff
        bq = 0; bs1 = 0; bd = 0;
        vif_b.btn1_raw = 1'b1;
        run_b(8, bq, bs1, bd);
        check("drop_first_select1", bs1, 1);
        vif_b.coin_raw = 1'b1;
        run_b(7, bq, bs1, bd);
        vif_b.coin_raw = 1'b0;
        run_b(7, bq, bs1, bd);
        vif_b.coin_raw = 1'b1;
        run_b(7, bq, bs1, bd);
        check("drop_before_issue_q", bq, 0);
        check("drop_pulse", bd, 1);
        vif_b.coin_raw = 1'b0;
        vif_b.btn1_raw = 1'b0;
        run_b(40, bq, bs1, bd);
        check("drop_quarter_total", bq, 1);
        check("drop_total", bd, 1);
        check("drop_select1_total", bs1, 1);
        check("drop_end_busy", int'(vif_b.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
